// File: rtl/conv_pkg.sv
// conv_pkg: FSM state encoding and columnControl bit positions shared by the convolution sequencer.
package conv_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;
  localparam int COL_EN     = 0;
  localparam int ACC_CLR    = 1;
  localparam int NLOAD      = 2;
  localparam int PSUM_VALID = 3;
endpackage

// File: rtl/conv_seq_counter.sv
// conv_seq_counter: enabled up-counter that wraps to zero at limit; carry flags the wrapping step.
module conv_seq_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] q,
  output logic         carry
);
  assign carry = en && q == limit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= carry ? '0 : q + W'(1);
endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: control sequencer for a DxD convolution mesh (config, kernel load, run, drain).
// Optional CONV_SEQ_STALL_EN adds a stall input that freezes LOAD/RUN/DRAIN.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int depth = 2,
  parameter int D     = (1 << depth),
  parameter int A     = 7
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic                     start,
`ifdef CONV_SEQ_STALL_EN
  input  logic                     stall,
`endif
  input  logic [depth-1:0]         ksize_m1,
  input  logic [A-1:0]             out_rows_m1,
  input  logic [A-1:0]             out_cols_m1,
  output logic                     busy,
  output logic                     done,
  output logic [D*8-1:0]           columnControl,
  output logic [depth*D-1:0]       rowControl,
  output logic [2*depth+2*A-1:0]   commonControl,
  output logic [2*depth-1:0]       kaddr,
  output logic [2*A-1:0]           naddr
);
  state_t state, nxt;
  logic [depth-1:0] ksize, kc, kr, kc_lim;
  logic [A-1:0] rows, cols, ocol, orow;
  logic [D-1:0] dl;
  logic stl, kc_en, kc_c, kr_c, oc_c, or_c, run, ld, cfg, acc, last;
`ifdef CONV_SEQ_STALL_EN
  assign stl = stall && (state == S_LOAD || state == S_RUN || state == S_DRAIN);
`else
  assign stl = 1'b0;
`endif
  assign run = state == S_RUN;
  assign ld = state == S_LOAD;
  assign cfg = state == S_CONFIG;
  // kc doubles as the LOAD column index and the DRAIN cycle counter
  assign kc_en = (ld || run || state == S_DRAIN) && !stl;
  assign kc_lim = state == S_DRAIN ? '1 : ksize;
  assign acc = run && kc == '0 && kr == '0 && !(ocol == '0 && orow == '0);
  assign last = run && !stl && kc == ksize && kr == ksize;
  conv_seq_counter #(.W(depth)) u_kc (
    .clk(CLK), .rst_n(RESETn), .en(kc_en), .limit(kc_lim), .q(kc), .carry(kc_c)
  );
  conv_seq_counter #(.W(depth)) u_kr (
    .clk(CLK), .rst_n(RESETn), .en(run && kc_c), .limit(ksize), .q(kr), .carry(kr_c)
  );
  conv_seq_counter #(.W(A)) u_ocol (
    .clk(CLK), .rst_n(RESETn), .en(kr_c), .limit(cols), .q(ocol), .carry(oc_c)
  );
  conv_seq_counter #(.W(A)) u_orow (
    .clk(CLK), .rst_n(RESETn), .en(oc_c), .limit(rows), .q(orow), .carry(or_c)
  );
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      state <= S_IDLE;
      ksize <= '0;
      rows <= '0;
      cols <= '0;
      dl <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start) begin
        ksize <= ksize_m1;
        rows <= out_rows_m1;
        cols <= out_cols_m1;
      end
      if (!stl) dl <= {dl[D-2:0], last};
    end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = start ? S_CONFIG : S_IDLE;
      S_CONFIG: nxt = S_LOAD;
      S_LOAD:   nxt = kc_c ? S_RUN : S_LOAD;
      S_RUN:    nxt = or_c ? S_DRAIN : S_RUN;
      S_DRAIN:  nxt = kc_c ? S_DONE : S_DRAIN;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    busy = state != S_IDLE;
    done = state == S_DONE;
  end
  always_comb begin
    columnControl = '0;
    for (int j = 0; j < D; j++) begin
      columnControl[j*8+COL_EN] = run && !stl && int'(ksize) >= j;
      columnControl[j*8+ACC_CLR] = cfg || acc;
      columnControl[j*8+NLOAD] = ld && !stl && kc == depth'(j);
      columnControl[j*8+PSUM_VALID] = dl[D-1];
    end
  end
  for (genvar i = 0; i < D; i++) begin : g_row
    assign rowControl[i*depth +: depth] = depth'(i);
  end
  assign commonControl = {ksize, kr, orow, ocol};
  assign kaddr = ld ? {kc, {depth{1'b0}}} : run ? {kr, kc} : '0;
  assign naddr = run ? {orow + A'(kr), ocol + A'(kc)} : '0;
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed self-checking bench for conv_sequencer (depth=2, D=4, A=7).
module tb_conv_sequencer;
  localparam int D = 4;
  logic CLK = 1'b0;
  logic RESETn, start;
  logic [1:0] ksize_m1;
  logic [6:0] out_rows_m1, out_cols_m1;
  logic busy, done;
  logic [31:0] columnControl;
  logic [7:0] rowControl;
  logic [17:0] commonControl;
  logic [3:0] kaddr;
  logic [13:0] naddr;
`ifdef CONV_SEQ_STALL_EN
  logic stall = 1'b0;
`endif
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] obs_col [64];
  logic [31:0] obs_nad [64];

  conv_sequencer dut (
    .CLK(CLK), .RESETn(RESETn), .start(start),
`ifdef CONV_SEQ_STALL_EN
    .stall(stall),
`endif
    .ksize_m1(ksize_m1), .out_rows_m1(out_rows_m1), .out_cols_m1(out_cols_m1),
    .busy(busy), .done(done), .columnControl(columnControl), .rowControl(rowControl),
    .commonControl(commonControl), .kaddr(kaddr), .naddr(naddr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_col"}, columnControl, 0);
    chk({tag, "_kaddr"}, kaddr, 0);
    chk({tag, "_naddr"}, naddr, 0);
    chk({tag, "_common"}, commonControl, 0);
    chk({tag, "_row"}, rowControl, 32'he4);
  endtask

  // Cycle t counts negedges after the start-sampling edge; st>0 stalls cycles st..st+2.
  task automatic run_job(input int ks, input int r, input int c, input int lat, input int hold, input int st);
    int k, n, s, ps, te, kc, kr, oc, orr;
    bit sn;
    logic [31:0] ecol, ekad, enad, ecom;
    k = ks + 1;
    n = k * k * (r + 1) * (c + 1);
    ksize_m1 = 2'(ks);
    out_rows_m1 = 7'(r);
    out_cols_m1 = 7'(c);
    start = 1'b1;
    for (int t = 1; t <= lat; t++) begin
      @(negedge CLK);
      if (hold == 0) start = 1'b0;
      sn = st != 0 && t >= st && t < st + 3;
      te = sn ? st - 1 : (st != 0 && t >= st + 3) ? t - 3 : t;
      s = te - 2 - k;
      ps = s - D;
      kc = 0; kr = 0; oc = 0; orr = 0;
      ecol = 0; ekad = 0; enad = 0;
      if (s >= 0 && s < n) begin
        kc = s % k;
        kr = (s / k) % k;
        oc = (s / (k * k)) % (c + 1);
        orr = s / (k * k * (c + 1));
      end
      if (te == 1) ecol = 32'h02020202;
      else if (te <= k + 1) begin
        ekad = (te - 2) * 4;
        ecol = 32'h4 << (8 * (te - 2));
      end else if (s < n) begin
        for (int j = 0; j < k; j++) ecol |= 32'h1 << (8 * j);
        if (kc == 0 && kr == 0 && s != 0) ecol |= 32'h02020202;
        ekad = kr * 4 + kc;
        enad = ((orr + kr) % 128) * 128 + (oc + kc) % 128;
      end
      if (ps >= 0 && ps < n && ps % (k * k) == k * k - 1) ecol |= 32'h08080808;
      if (sn) ecol &= 32'hfafafafa;
      ecom = ks * 65536 + kr * 16384 + orr * 128 + oc;
      chk("col", columnControl, ecol);
      chk("kaddr", kaddr, ekad);
      chk("naddr", naddr, enad);
      chk("common", commonControl, ecom);
      chk("busy", busy, 1);
      chk("done", done, 32'(t == lat));
      obs_col[t] = columnControl;
      obs_nad[t] = naddr;
`ifdef CONV_SEQ_STALL_EN
      stall = st != 0 && t + 1 >= st && t + 1 < st + 3;
`endif
    end
    @(negedge CLK);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    if (hold != 0) begin
      @(negedge CLK);
      chk("restart_col", columnControl, 32'h02020202);
      chk("restart_busy", busy, 1);
      start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RESETn = 1'b0;
    start = 1'b0;
    ksize_m1 = '0;
    out_rows_m1 = '0;
    out_cols_m1 = '0;
    repeat (2) @(negedge CLK);
    chk_zero("reset");
    RESETn = 1'b1;
    @(negedge CLK);
    run_job(2, 0, 0, 18, 0, 0);
    chk("k3_run0", obs_col[5], 32'h00010101);
    chk("k3_psum", obs_col[17], 32'h08080808);
    run_job(1, 1, 1, 24, 0, 0);
    chk("p11_s0", obs_nad[16], 32'h81);
    chk("p11_s1", obs_nad[17], 32'h82);
    chk("p11_s2", obs_nad[18], 32'h101);
    chk("p11_s3", obs_nad[19], 32'h102);
    chk("k2_first", obs_col[4], 32'h00000101);
    chk("k2_acc", obs_col[8], 32'h02020303);
    run_job(0, 0, 3, 11, 0, 0);
    chk("k1_run0", obs_col[3], 32'h00000001);
    chk("k1_run1", obs_col[4], 32'h02020203);
    for (int t = 7; t <= 10; t++) chk("k1_psum", obs_col[t], 32'h08080808);
    ksize_m1 = 2'd2;
    out_rows_m1 = '0;
    out_cols_m1 = '0;
    start = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      @(negedge CLK);
      start = 1'b0;
      chk("pre_rst_done", done, 0);
    end
    RESETn = 1'b0;
    #1;
    chk_zero("midrun");
    for (int t = 0; t < 3; t++) begin
      @(negedge CLK);
      chk("rst_hold_done", done, 0);
    end
    RESETn = 1'b1;
    run_job(2, 0, 0, 18, 0, 0);
    run_job(0, 0, 0, 8, 1, 0);
    RESETn = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    chk("post_hold_busy", busy, 0);
`ifdef CONV_SEQ_STALL_EN
    run_job(1, 1, 1, 27, 0, 10);
    chk("stall_p11", obs_nad[22], 32'h102);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have parameter depth, default 2, log2 of mesh dimension.
REQ-002 SHALL have parameter D, default (1<<depth), mesh rows = columns.
REQ-003 SHALL have parameter A, default 7, width of output-map coordinate.
REQ-004 SHALL have port CLK input 1, the single clock; all state on rising edge.
REQ-005 SHALL have port RESETn input 1, asynchronous active-low reset.
REQ-006 SHALL have port start input 1, level; sampled only in IDLE.
REQ-007 SHALL have port ksize_m1 input depth, kernel size minus one (K = ksize_m1+1, K<=D).
REQ-008 SHALL have port out_rows_m1 input A and port out_cols_m1 input A, output-map size minus one.
REQ-009 SHALL have port busy output 1, high in every state except IDLE.
REQ-010 SHALL have port done output 1, one-cycle pulse on DONE.
REQ-011 SHALL have port columnControl output D*8, per column byte: bit0 col_en, bit1 acc_clr, bit2 nload, bit3 psum_valid, bits7:4 zero.
REQ-012 SHALL have port rowControl output depth*D, field i = row index i.
REQ-013 SHALL have port commonControl output 2*depth+2*A = {ksize_m1, kr, orow, ocol} with kr sized depth.
REQ-014 SHALL have port kaddr output 2*depth and port naddr output 2*A, kernel/neuron buffer read addresses.

Function
REQ-015 SHALL implement FSM IDLE -> CONFIG -> LOAD -> RUN -> DRAIN -> DONE -> IDLE.
REQ-016 IDLE->CONFIG on start=1; configuration inputs latched on that edge, ignored afterwards.
REQ-017 CONFIG SHALL last 1 cycle, driving rowControl fields and acc_clr=1 on all columns.
REQ-018 LOAD SHALL last K cycles; cycle n: kaddr={n,0}, nload=1 on column n only.
REQ-019 RUN SHALL step kernel column kc 0..K-1 inner, kernel row kr 0..K-1 middle, ocol 0..out_cols_m1, orow 0..out_rows_m1 outer, one step per cycle.
REQ-020 In RUN, col_en=1 for columns j<K, else 0; kaddr={kr,kc}; naddr={orow+kr, ocol+kc} (each A bits, modulo 2^A).
REQ-021 acc_clr SHALL pulse on the first RUN cycle of every output position (kr=kc=0), except the first (covered by CONFIG).
REQ-022 psum_valid SHALL assert on all columns D cycles after each position's last step (kr=kc=K-1), via a D-deep delay line.
REQ-023 RUN->DRAIN after final step (all counters at max); DRAIN SHALL last exactly D cycles, col_en=0.
REQ-024 DONE lasts 1 cycle; done=1, busy=1; start held high then re-triggers from IDLE next cycle.
REQ-025 Total latency start->done = 1+K+K*K*(R+1)*(C+1)+D+1 cycles after the IDLE edge (R=out_rows_m1, C=out_cols_m1).
REQ-026 ksize_m1=0 SHALL give a 1-cycle-per-position run, acc_clr on every RUN cycle except the first.

Reset
REQ-027 RESETn=0 SHALL immediately force IDLE, all counters 0, delay line 0, busy=0, done=0, columnControl=0, kaddr=0, naddr=0, commonControl=0; rowControl stays constant.
REQ-028 Reset mid-RUN SHALL abandon the job; no done pulse; next start begins a fresh job.

Configuration
REQ-029 Macro CONV_SEQ_STALL_EN SHALL add input stall (1 bit).
REQ-030 With it, stall=1 in LOAD/RUN/DRAIN freezes counters, FSM and delay line; col_en and nload forced 0; outputs otherwise hold.
REQ-031 Without it, no stall port exists and the sequence never pauses.

Structure
REQ-032 Package conv_pkg SHALL hold the FSM state encoding and columnControl bit-position constants.
REQ-033 Sub-module conv_seq_counter (wrap-at-limit counter with enable and carry) SHALL be instantiated for kc, kr, ocol, orow.

Verification
REQ-034 D=4, K=3, R=C=0, start pulse -> done after 1+3+9+4+1=18 cycles; col_en columns 0..2 only.
REQ-035 K=2, R=1, C=1 -> naddr sequence for position (1,1) = {1,1},{1,2},{2,1},{2,2}; acc_clr at each position's first step.
REQ-036 K=1, R=0, C=3 -> 4 RUN cycles, psum_valid 4 pulses beginning 4 cycles after each step.
REQ-037 RESETn low at RUN cycle 5 -> all outputs 0 same cycle, no done; restart completes normally.
REQ-038 With CONV_SEQ_STALL_EN, stall 3 cycles mid-RUN -> done delayed exactly 3 cycles; address sequence unchanged.
REQ-039 start held high through DONE -> new CONFIG on the cycle after returning to IDLE.
